// File: rtl/cm_ord_tree.sv
// Pipelined min/max binary-tree reducer over N channels; returns winning value and channel index.
// Latency: REG_CNT cycles from accepted input to o_vld (REG_CNT=0 is purely combinational).
// Backpressure: each register stage holds its contents while stalled; o_rdy is the stage-0 accept.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_vld / o_rdy         input vector handshake, i_data channel c at [c*W +: W]
//   o_vld / i_rdy         result handshake, o_data selected value, o_idx winning channel
//   i_mask / o_none       only when CM_ORD_TREE_MASK_EN is defined: per-channel participate
//                         mask, and a flag raised when no channel participated
//
// Tie-break: the left (even) node of every pair always covers lower channel indices, so on equal
// values the left node is kept; the lowest index therefore wins at every level.

package cm_pkg;
    typedef enum logic [1:0] {ORD_MIN, ORD_MAX, ORD_SORT} t_ord_type;
endpackage

module cm_ord_tree #(
    parameter int                N       = 8,
    parameter int                W       = 16,
    parameter cm_pkg::t_ord_type ORD     = cm_pkg::ORD_MIN,
    parameter bit                SIGNED  = 1'b0,
    parameter int                REG_CNT = 2,
    localparam int               LVL     = $clog2(N),
    localparam int               IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic [N*W-1:0]  i_data,
`ifdef CM_ORD_TREE_MASK_EN
    input  logic [N-1:0]    i_mask,
    output logic            o_none,
`endif
    output logic            o_vld,
    input  logic            i_rdy,
    output logic [W-1:0]    o_data,
    output logic [IW-1:0]   o_idx
);

    // Elaboration-time parameter checks
    if (ORD == cm_pkg::ORD_SORT) begin : g_bad_ord
        $error("cm_ord_tree: ORD_SORT is not supported by the reducer");
    end
    if (N < 1 || W < 1) begin : g_bad_size
        $error("cm_ord_tree: N and W must both be >= 1");
    end
    if (REG_CNT < 0 || REG_CNT > LVL) begin : g_bad_reg
        $error("cm_ord_tree: REG_CNT must lie in 0..$clog2(N)");
    end

    // Node value / index / participate flag at the input of each level (level LVL = root)
    logic [W-1:0]  nv    [LVL+1][N];
    logic [IW-1:0] ni    [LVL+1][N];
    logic          np    [LVL+1][N];
    // Handshake at each level boundary
    logic          vld_b [LVL+1];
    logic          rdy_b [LVL+1];

    // Returns 1 when the right node b strictly beats the left node a.
    // A non-participating node never beats a participating one; between two
    // non-participating nodes the left is kept so an all-masked tree ends at index 0.
    function automatic logic b_wins(input logic [W-1:0] a, input logic ap,
                                    input logic [W-1:0] b, input logic bp);
        logic lt;
        logic gt;
        if (ap != bp) begin
            return bp;
        end
        if (!ap) begin
            return 1'b0;
        end
        if (SIGNED) begin
            lt = $signed(b) < $signed(a);
            gt = $signed(b) > $signed(a);
        end else begin
            lt = b < a;
            gt = b > a;
        end
        return (ORD == cm_pkg::ORD_MAX) ? gt : lt;
    endfunction

    // Leaf level: masked channels enter with value 0 so an all-masked result reads back as 0
    for (genvar c = 0; c < N; c++) begin : g_in
`ifdef CM_ORD_TREE_MASK_EN
        assign np[0][c] = i_mask[c];
`else
        assign np[0][c] = 1'b1;
`endif
        assign nv[0][c] = np[0][c] ? i_data[c*W +: W] : '0;
        assign ni[0][c] = IW'(c);
    end

    assign vld_b[0]   = i_vld;
    assign rdy_b[LVL] = i_rdy;

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int CI     = (N + (1 << l) - 1) >> l;
        localparam int CO     = (N + (1 << (l + 1)) - 1) >> (l + 1);
        // Spread REG_CNT registers evenly over the LVL levels
        localparam bit REG_EN = (((l + 1) * REG_CNT) / LVL) > ((l * REG_CNT) / LVL);

        logic [W-1:0]  cv [N];
        logic [IW-1:0] ci [N];
        logic          cp [N];

        always_comb begin
            for (int k = 0; k < N; k++) begin
                cv[k] = '0;
                ci[k] = '0;
                cp[k] = 1'b0;
            end
            for (int k = 0; k < CO; k++) begin
                if (2*k + 1 < CI) begin
                    if (b_wins(nv[l][2*k], np[l][2*k], nv[l][2*k+1], np[l][2*k+1])) begin
                        cv[k] = nv[l][2*k+1];
                        ci[k] = ni[l][2*k+1];
                        cp[k] = np[l][2*k+1];
                    end else begin
                        cv[k] = nv[l][2*k];
                        ci[k] = ni[l][2*k];
                        cp[k] = np[l][2*k];
                    end
                end else begin
                    // Odd node out at this level passes straight through
                    cv[k] = nv[l][2*k];
                    ci[k] = ni[l][2*k];
                    cp[k] = np[l][2*k];
                end
            end
        end

        if (REG_EN) begin : g_reg
            logic          vld_q, vld_d;
            logic          acc;
            logic [W-1:0]  v_q [N];
            logic [W-1:0]  v_d [N];
            logic [IW-1:0] i_q [N];
            logic [IW-1:0] i_d [N];
            logic          p_q [N];
            logic          p_d [N];

            always_comb begin
                acc   = !vld_q || rdy_b[l+1];
                vld_d = acc ? vld_b[l] : vld_q;
                for (int k = 0; k < N; k++) begin
                    v_d[k] = v_q[k];
                    i_d[k] = i_q[k];
                    p_d[k] = p_q[k];
                    // Only capture real vectors so a drained stage keeps its last contents
                    if (acc && vld_b[l]) begin
                        v_d[k] = cv[k];
                        i_d[k] = ci[k];
                        p_d[k] = cp[k];
                    end
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    vld_q <= 1'b0;
                    for (int k = 0; k < N; k++) begin
                        v_q[k] <= '0;
                        i_q[k] <= '0;
                        p_q[k] <= 1'b1;   // reads as "something participated" so o_none resets low
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int k = 0; k < N; k++) begin
                        v_q[k] <= v_d[k];
                        i_q[k] <= i_d[k];
                        p_q[k] <= p_d[k];
                    end
                end
            end

            assign rdy_b[l]   = acc;
            assign vld_b[l+1] = vld_q;
            for (genvar k = 0; k < N; k++) begin : g_out
                assign nv[l+1][k] = v_q[k];
                assign ni[l+1][k] = i_q[k];
                assign np[l+1][k] = p_q[k];
            end
        end else begin : g_comb
            assign rdy_b[l]   = rdy_b[l+1];
            assign vld_b[l+1] = vld_b[l];
            for (genvar k = 0; k < N; k++) begin : g_out
                assign nv[l+1][k] = cv[k];
                assign ni[l+1][k] = ci[k];
                assign np[l+1][k] = cp[k];
            end
        end
    end

    assign o_rdy  = rdy_b[0];
    assign o_vld  = vld_b[LVL];
    assign o_data = nv[LVL][0];
    assign o_idx  = ni[LVL][0];
`ifdef CM_ORD_TREE_MASK_EN
    assign o_none = !np[LVL][0];
`endif

endmodule

// File: tb/tb_cm_ord_tree.sv
// Directed bench for cm_ord_tree: min/max/signed/combinational variants share one input bus.
// Latency: results checked 2 cycles after acceptance for the REG_CNT=2 instances.
// Backpressure: a stall window on i_rdy exercises hold, o_rdy deassertion and ordering.

module tb_cm_ord_tree;

    logic         clk;
    logic         i_rst;
    logic         i_vld;
    logic         i_rdy;
    logic [127:0] i_data;
`ifdef CM_ORD_TREE_MASK_EN
    logic [7:0]   i_mask;
    logic         min_none, max_none, s5_none, s5c_none;
`endif

    logic         min_rdy, min_vld;
    logic [15:0]  min_data;
    logic [2:0]   min_idx;
    logic         max_rdy, max_vld;
    logic [15:0]  max_data;
    logic [2:0]   max_idx;
    logic         s5_rdy, s5_vld;
    logic [15:0]  s5_data;
    logic [2:0]   s5_idx;
    logic         s5c_rdy, s5c_vld;
    logic [15:0]  s5c_data;
    logic [2:0]   s5c_idx;

    int n_chk = 0;
    int n_err = 0;
    int sent;
    int got;

    cm_ord_tree #(.N(8), .W(16), .ORD(cm_pkg::ORD_MIN), .SIGNED(1'b0), .REG_CNT(2)) u_min (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(min_rdy), .i_data(i_data),
`ifdef CM_ORD_TREE_MASK_EN
        .i_mask(i_mask), .o_none(min_none),
`endif
        .o_vld(min_vld), .i_rdy(i_rdy), .o_data(min_data), .o_idx(min_idx)
    );

    cm_ord_tree #(.N(8), .W(16), .ORD(cm_pkg::ORD_MAX), .SIGNED(1'b0), .REG_CNT(2)) u_max (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(max_rdy), .i_data(i_data),
`ifdef CM_ORD_TREE_MASK_EN
        .i_mask(i_mask), .o_none(max_none),
`endif
        .o_vld(max_vld), .i_rdy(i_rdy), .o_data(max_data), .o_idx(max_idx)
    );

    cm_ord_tree #(.N(5), .W(16), .ORD(cm_pkg::ORD_MIN), .SIGNED(1'b1), .REG_CNT(2)) u_s5 (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(s5_rdy), .i_data(i_data[79:0]),
`ifdef CM_ORD_TREE_MASK_EN
        .i_mask(i_mask[4:0]), .o_none(s5_none),
`endif
        .o_vld(s5_vld), .i_rdy(i_rdy), .o_data(s5_data), .o_idx(s5_idx)
    );

    cm_ord_tree #(.N(5), .W(16), .ORD(cm_pkg::ORD_MIN), .SIGNED(1'b1), .REG_CNT(0)) u_s5c (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(s5c_rdy), .i_data(i_data[79:0]),
`ifdef CM_ORD_TREE_MASK_EN
        .i_mask(i_mask[4:0]), .o_none(s5c_none),
`endif
        .o_vld(s5c_vld), .i_rdy(i_rdy), .o_data(s5c_data), .o_idx(s5c_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set8(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                        input logic [15:0] c3, input logic [15:0] c4, input logic [15:0] c5,
                        input logic [15:0] c6, input logic [15:0] c7);
        i_data = {c7, c6, c5, c4, c3, c2, c1, c0};
    endtask

    // Stream vector k: channel k holds 10+k, all others 100, so the min is 10+k at index k
    task automatic load_vec(input int k);
        for (int c = 0; c < 8; c++) begin
            i_data[c*16 +: 16] = (c == k) ? 16'(10 + k) : 16'd100;
        end
    endtask

    initial begin
        i_rst  = 1'b1;
        i_vld  = 1'b0;
        i_rdy  = 1'b1;
        i_data = '0;
`ifdef CM_ORD_TREE_MASK_EN
        i_mask = 8'hFF;
`endif
        repeat (2) @(negedge clk);
        chk("rst_min_vld",  min_vld,  0);
        chk("rst_min_data", min_data, 0);
        chk("rst_min_idx",  min_idx,  0);
        chk("rst_max_vld",  max_vld,  0);
        chk("rst_s5_vld",   s5_vld,   0);
        chk("rst_min_rdy",  min_rdy,  1);
        i_rst = 1'b0;

        // Basic min/max with a 2-cycle pipeline
        @(negedge clk);
        set8(9, 4, 7, 4, 12, 30, 1, 5);
        i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        chk("lat_cycle1_vld", min_vld, 0);
        @(negedge clk);
        chk("min_vld",  min_vld,  1);
        chk("min_data", min_data, 1);
        chk("min_idx",  min_idx,  6);
        chk("max_data", max_data, 30);
        chk("max_idx",  max_idx,  5);
        @(negedge clk);
        chk("min_vld_drop", min_vld, 0);

        // Ties: all equal, then a max tie between channels 1 and 2 and a min tie over 4..7
        set8(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
        i_vld = 1'b1;
        @(negedge clk);
        set8(3, 8, 8, 2, 0, 0, 0, 0);
        @(negedge clk);
        i_vld = 1'b0;
        chk("tie_all_max_data", max_data, 16'h00FF);
        chk("tie_all_max_idx",  max_idx,  0);
        chk("tie_all_min_idx",  min_idx,  0);
        @(negedge clk);
        chk("tie_max_data", max_data, 8);
        chk("tie_max_idx",  max_idx,  1);
        chk("tie_min_data", min_data, 0);
        chk("tie_min_idx",  min_idx,  4);
        @(negedge clk);

        // Signed N=5, registered and combinational; the 8-channel unsigned min sees 0 at index 2
        set8(3, 16'hFFFE, 0, 16'hFFFE, 7, 0, 0, 0);
        i_vld = 1'b1;
        #1;
        chk("s5c_vld",  s5c_vld,  1);
        chk("s5c_data", s5c_data, 16'hFFFE);
        chk("s5c_idx",  s5c_idx,  1);
        @(negedge clk);
        i_vld = 1'b0;
        @(negedge clk);
        chk("s5_vld",       s5_vld,   1);
        chk("s5_data",      s5_data,  16'hFFFE);
        chk("s5_idx",       s5_idx,   1);
        chk("unsigned_data", min_data, 0);
        chk("unsigned_idx",  min_idx,  2);
        i_rdy = 1'b0;
        #1;
        chk("s5c_rdy_follow", s5c_rdy, 0);
        i_rdy = 1'b1;
        @(negedge clk);

        // Backpressure: 6 back-to-back vectors, downstream stalls in cycles 3..5
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            i_rdy = !(cyc >= 3 && cyc <= 5);
            if (sent < 6) begin
                load_vec(sent);
                i_vld = 1'b1;
            end else begin
                i_vld = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                chk("bp_rdy_full",  min_rdy,  0);
                chk("bp_hold_vld",  min_vld,  1);
                chk("bp_hold_data", min_data, 32'(10 + got));
                chk("bp_hold_idx",  min_idx,  32'(got));
            end
            if (min_vld && i_rdy) begin
                chk("bp_no_extra", (got < 6), 1);
                chk("bp_data", min_data, 32'(10 + got));
                chk("bp_idx",  min_idx,  32'(got));
                got++;
            end
            if (i_vld && min_rdy) sent++;
            @(negedge clk);
        end
        chk("bp_count_out", got,  6);
        chk("bp_count_in",  sent, 6);
        i_vld = 1'b0;
        i_rdy = 1'b1;

        // Reset with two vectors in flight
        load_vec(0);
        i_vld = 1'b1;
        @(negedge clk);
        load_vec(1);
        @(negedge clk);
        i_vld = 1'b0;
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", min_vld, 0);
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_no_stale", min_vld, 0);
        end

`ifdef CM_ORD_TREE_MASK_EN
        // Masking: channels 1,3,4,5,7 participate; then nothing participates
        set8(9, 4, 7, 4, 12, 30, 1, 5);
        i_mask = 8'b1011_1010;
        i_vld  = 1'b1;
        @(negedge clk);
        i_mask = 8'h00;
        @(negedge clk);
        i_vld = 1'b0;
        chk("mask_data", min_data, 4);
        chk("mask_idx",  min_idx,  1);
        chk("mask_none", min_none, 0);
        @(negedge clk);
        chk("none_vld",  min_vld,  1);
        chk("none_flag", min_none, 1);
        chk("none_data", min_data, 0);
        chk("none_idx",  min_idx,  0);
        i_mask = 8'hFF;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
